// File: rtl/mem_read_tracker.sv
// mem_read_tracker
//   Sits between pattern_decoder's memory request port and the memory system.
//   Forwards tagged reads to memory, caps the number of outstanding reads,
//   keeps the tags of issued reads in an in-order FIFO, and reattaches the
//   oldest tag to each in-order memory response before pushing it to the
//   decoder. A level flush stops new issue and drains outstanding reads.
//
//   Optional feature macro: MEM_READ_TRACKER_STATS_EN
//     Defined   : adds stat_reqs / stat_stall_cycles counter ports.
//     Undefined : those ports and counters do not exist.
//
//   Handshake semantics (all interfaces):
//     Issue side: req is the valid, ~req_stall is the ready. A read transfers
//       in any cycle where req=1 and req_stall=0. req_stall never looks at req,
//       so the decoder may gate req with it without a combinational loop.
//     Memory request side: mem_req is the valid, ~mem_stall is the ready.
//       mem_stall is folded into req_stall, so mem_req only rises in cycles
//       the memory accepts it.
//     Memory response side: mem_rsp is a valid with no ready; responses are
//       always consumed and arrive in issue order.
//     Decoder push side: push is a one-cycle valid with no ready.
//   dbg_state exposes the flush FSM state (0=RUN, 1=DRAIN, 2=DONE).

module mem_read_tracker #(
  parameter int ADDR_WIDTH   = 48,
  parameter int DATA_WIDTH   = 64,
  parameter int TAG_COUNT    = 4,
  parameter int TAG_WIDTH    = $clog2(TAG_COUNT),
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_stall,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_stall,
  input  logic                  mem_rsp,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  push,
  output logic [TAG_WIDTH-1:0]  push_tag,
  output logic [DATA_WIDTH-1:0] data,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  rsp_err,
  output logic [1:0]            dbg_state
`ifdef MEM_READ_TRACKER_STATS_EN
  ,
  output logic [31:0]           stat_reqs,
  output logic [31:0]           stat_stall_cycles
`endif
);

  // Pointer width indexes the tag FIFO; the count needs one extra bit so that
  // a completely full FIFO (MAX_INFLIGHT entries) is representable.
  localparam int PTR_W = $clog2(MAX_INFLIGHT);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               state;

  // Tag FIFO storage and bookkeeping. The occupancy count doubles as the
  // number of reads outstanding at the memory.
  logic [TAG_WIDTH-1:0] tag_mem [MAX_INFLIGHT];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     inflight;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 tag_wr;
  logic                 tag_pop;

  assign fifo_full  = (inflight == FULL_CNT);
  assign fifo_empty = (inflight == '0);

  // Back-pressure is built only from registered state and mem_stall. A
  // response in the same cycle as a full FIFO does not lower the stall; the
  // freed slot becomes visible once the count register has updated.
  assign req_stall = mem_stall | fifo_full | (state != ST_RUN);

  // Zero-latency issue path: the address passes straight through and the
  // request is only qualified by the stall.
  assign mem_req  = req & ~req_stall;
  assign mem_addr = req_addr;

  // A tag is written whenever a read is issued. A pop needs a tag that was
  // already stored at the start of the cycle, so an empty FIFO never pops
  // the tag being written in that same cycle.
  assign tag_wr  = mem_req;
  assign tag_pop = mem_rsp & ~fifo_empty;

  assign dbg_state = state;

  // Tag storage: written at the write pointer on each issued read. Contents
  // need no reset because the count gates every read of them.
  always_ff @(posedge clk) begin
    if (tag_wr) begin
      tag_mem[wr_ptr] <= req_tag;
    end
  end

  // FIFO pointers and occupancy; a simultaneous write and pop leaves the
  // count unchanged. Pointers wrap naturally because depth is a power of 2.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= '0;
    end else begin
      if (tag_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (tag_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({tag_wr, tag_pop})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Response path: one cycle after a matched response, push the data with
  // the oldest tag. data/push_tag hold their value between pushes. A response
  // with nothing outstanding is dropped and flagged in the sticky rsp_err.
  always_ff @(posedge clk) begin
    if (!rst) begin
      push     <= 1'b0;
      push_tag <= '0;
      data     <= '0;
      rsp_err  <= 1'b0;
    end else begin
      push <= tag_pop;
      if (tag_pop) begin
        push_tag <= tag_mem[rd_ptr];
        data     <= mem_rsp_data;
      end
      if (mem_rsp && fifo_empty) begin
        rsp_err <= 1'b1;
      end
    end
  end

  // Flush FSM: RUN stops issuing on flush, DRAIN waits for every outstanding
  // read to return (and no stray response this cycle), DONE holds until the
  // flush request drops. flush_done is registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_RUN;
      flush_done <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (flush) begin
            state <= ST_DRAIN;
          end
          flush_done <= 1'b0;
        end
        ST_DRAIN: begin
          if (fifo_empty && !mem_rsp) begin
            state      <= ST_DONE;
            flush_done <= 1'b1;
          end else begin
            flush_done <= 1'b0;
          end
        end
        ST_DONE: begin
          if (!flush) begin
            state      <= ST_RUN;
            flush_done <= 1'b0;
          end else begin
            flush_done <= 1'b1;
          end
        end
        default: begin
          state      <= ST_RUN;
          flush_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_READ_TRACKER_STATS_EN
  // Statistics: issued reads, and cycles where the decoder is held off while
  // the tracker is running. Free-running 32-bit wrap, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_reqs         <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (mem_req) begin
        stat_reqs <= stat_reqs + 32'd1;
      end
      if (req_stall && (state == ST_RUN)) begin
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
